z80_bus_target: RTL and testbench

Z80_BUS_TARGET -- requirements
Module: z80_bus_target

---
 rtl/z80_bus_target.sv | 147 ++++++++++++++
 tb/tb_z80_bus_target.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_target.sv
// Z80 bus target: RAM window, console output FIFO on one I/O port, wait-state
// generation and a sticky halt detector, all on the single MCLK domain.
module z80_bus_target #(
  parameter int unsigned RAM_AW   = 15,
  parameter logic [15:0] RAM_BASE = 16'h8000,
  parameter logic [7:0]  CON_PORT = 8'h10,
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 4
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic [15:0] ADDRESS,
  input  logic [7:0]  DATA_o,
  output logic [7:0]  DATA_i,
  input  logic        MREQ,
  input  logic        IORQ,
  input  logic        RD,
  input  logic        WR,
  input  logic        M1,
  input  logic        RFSH,
  input  logic        HALT,
  output logic        WAIT,
  output logic [7:0]  CON_DATA,
  output logic        CON_VALID,
  input  logic        CON_READY,
  output logic        CON_OVF,
  output logic        HALTED
);

  localparam int unsigned RAM_DEPTH  = 2 ** RAM_AW;
  localparam int unsigned FIFO_DEPTH = 2 ** FIFO_AW;
  localparam int unsigned PW         = FIFO_AW + 1;
  localparam int unsigned WCW        = 8;

  logic [7:0]     ram [RAM_DEPTH];
  logic [7:0]     fifo_mem [FIFO_DEPTH];

  logic           mreq_q, iorq_q, wr_q, halt_q;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           wait_q;
  logic [7:0]     rdata_q, rdata_d;
  logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic           valid_q;
  logic [7:0]     cdata_q, cdata_d;
  logic           ovf_q, ovf_d;
  logic           halted_q;

  logic [16:0]        ram_off;
  logic               in_range;
  logic [RAM_AW-1:0]  ram_idx;
  logic               mem_start, io_start, con_sel, mem_wr, con_push;
  logic               full_c, pop_c, push_ok;
  logic               unused_rd;

  assign unused_rd = RD;

  // Address decode; below-base addresses wrap to a large offset and fall out of range.
  assign ram_off  = {1'b0, ADDRESS} - {1'b0, RAM_BASE};
  assign in_range = ram_off < 17'(RAM_DEPTH);
  assign ram_idx  = ram_off[RAM_AW-1:0];
  assign con_sel  = !IORQ && M1 && (ADDRESS[7:0] == CON_PORT);

  assign mem_start = mreq_q && !MREQ && RFSH;
  assign io_start  = iorq_q && !IORQ && M1;
  assign mem_wr    = wr_q && !WR && !MREQ && RFSH && in_range;
  assign con_push  = wr_q && !WR && con_sel;

  assign full_c  = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                   (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign pop_c   = valid_q && CON_READY;
  // A full FIFO still takes a push when the same cycle pops.
  assign push_ok = con_push && (!full_c || pop_c);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    ovf_d   = ovf_q;
    cdata_d = cdata_q;
    if (push_ok) wp_d = wp_q + PW'(1);
    if (pop_c)   rp_d = rp_q + PW'(1);
    if (con_push && !push_ok) ovf_d = 1'b1;
    // Head register must see a byte being written into the slot it will point at.
    if (push_ok && (rp_d[FIFO_AW-1:0] == wp_q[FIFO_AW-1:0])) cdata_d = DATA_o;
    else                                                      cdata_d = fifo_mem[rp_d[FIFO_AW-1:0]];
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (io_start)                wait_cnt_d = WCW'(IO_WAIT);
    else if (mem_start)          wait_cnt_d = WCW'(MEM_WAIT);
    else if (wait_cnt_q != '0)   wait_cnt_d = wait_cnt_q - WCW'(1);
  end

  always_comb begin
    rdata_d = 8'hFF;
    if (!IORQ && !M1)  rdata_d = 8'hFF;
    else if (con_sel)  rdata_d = {ovf_q, full_c, 5'b0, valid_q};
    else if (in_range) rdata_d = ram[ram_idx];
  end

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      mreq_q     <= 1'b1;
      iorq_q     <= 1'b1;
      wr_q       <= 1'b1;
      halt_q     <= 1'b1;
      wait_cnt_q <= '0;
      wait_q     <= 1'b1;
      rdata_q    <= 8'hFF;
      wp_q       <= '0;
      rp_q       <= '0;
      valid_q    <= 1'b0;
      cdata_q    <= 8'h00;
      ovf_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      mreq_q     <= MREQ;
      iorq_q     <= IORQ;
      wr_q       <= WR;
      halt_q     <= HALT;
      wait_cnt_q <= wait_cnt_d;
      wait_q     <= (wait_cnt_d == '0);
      rdata_q    <= rdata_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      valid_q    <= (wp_d != rp_d);
      cdata_q    <= cdata_d;
      ovf_q      <= ovf_d;
      if (!HALT && !halt_q) halted_q <= 1'b1;
    end
  end

  // Storage arrays carry no reset; RAM survives reset by design.
  always_ff @(posedge MCLK) begin
    if (mem_wr)  ram[ram_idx] <= DATA_o;
    if (push_ok) fifo_mem[wp_q[FIFO_AW-1:0]] <= DATA_o;
  end

  assign DATA_i    = rdata_q;
  assign WAIT      = wait_q;
  assign CON_DATA  = cdata_q;
  assign CON_VALID = valid_q;
  assign CON_OVF   = ovf_q;
  assign HALTED    = halted_q;

endmodule

// File: tb/tb_z80_bus_target.sv
// Self-checking bench for z80_bus_target: a console FIFO model and read-expectation
// queue act as scoreboards for memory, console, wait, halt and reset behaviour.
module tb_z80_bus_target;

  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned DEPTH   = 2 ** FIFO_AW;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic [15:0] ADDRESS;
  logic [7:0]  DATA_o;
  logic [7:0]  DATA_i;
  logic        MREQ, IORQ, RD, WR, M1, RFSH, HALT;
  logic        WAIT;
  logic [7:0]  CON_DATA;
  logic        CON_VALID;
  logic        CON_READY;
  logic        CON_OVF;
  logic        HALTED;

  int checks   = 0;
  int failures = 0;

  logic [7:0] con_q[$];
  logic [7:0] rd_q[$];
  logic       model_ovf;

  z80_bus_target #(.FIFO_AW(FIFO_AW)) dut (
    .MCLK(MCLK), .RESET(RESET), .ADDRESS(ADDRESS), .DATA_o(DATA_o), .DATA_i(DATA_i),
    .MREQ(MREQ), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1), .RFSH(RFSH), .HALT(HALT),
    .WAIT(WAIT), .CON_DATA(CON_DATA), .CON_VALID(CON_VALID), .CON_READY(CON_READY),
    .CON_OVF(CON_OVF), .HALTED(HALTED)
  );

  always #5 MCLK = ~MCLK;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b0;
    #3;
    con_q.delete();
    model_ovf = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
  endtask

  task automatic check_con(input string tag);
    check_eq({tag, "_valid"}, 16'(CON_VALID), 16'(con_q.size() != 0));
    if (con_q.size() != 0) check_eq({tag, "_data"}, 16'(CON_DATA), 16'(con_q[0]));
    check_eq({tag, "_ovf"}, 16'(CON_OVF), 16'(model_ovf));
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    ADDRESS = a; DATA_o = d; MREQ = 1'b0;
    tick();
    WR = 1'b0;
    tick();
    WR = 1'b1; MREQ = 1'b1;
    tick();
  endtask

  // Expected read data is queued when the read is driven and popped one MCLK later.
  task automatic mem_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    int low_cnt;
    rd_q.push_back(exp);
    ADDRESS = a; MREQ = 1'b0; RD = 1'b0;
    low_cnt = 0;
    tick();
    check_eq(tag, 16'(DATA_i), 16'(rd_q.pop_front()));
    for (int i = 0; i < 5; i++) begin
      if (!WAIT) low_cnt++;
      tick();
    end
    check_eq({tag, "_waitlow"}, 16'(low_cnt), 16'd0);
    MREQ = 1'b1; RD = 1'b1;
    tick();
  endtask

  task automatic io_write(input logic [7:0] d, input logic pop);
    if (pop && con_q.size() != 0) void'(con_q.pop_front());
    if (con_q.size() < DEPTH) con_q.push_back(d);
    else model_ovf = 1'b1;
    ADDRESS = 16'h0010; DATA_o = d; IORQ = 1'b0; WR = 1'b0; CON_READY = pop;
    tick();
    CON_READY = 1'b0; IORQ = 1'b1; WR = 1'b1;
    tick();
  endtask

  task automatic con_pop(input string tag);
    if (con_q.size() != 0) void'(con_q.pop_front());
    CON_READY = 1'b1;
    tick();
    CON_READY = 1'b0;
    check_con(tag);
  endtask

  initial begin
    int n;
    ADDRESS = 16'h0000; DATA_o = 8'h00;
    MREQ = 1'b1; IORQ = 1'b1; RD = 1'b1; WR = 1'b1; M1 = 1'b1; RFSH = 1'b1; HALT = 1'b1;
    CON_READY = 1'b0;
    model_ovf = 1'b0;
    RESET = 1'b0;
    #12;
    check_eq("rst_data_i", 16'(DATA_i), 16'h00FF);
    check_eq("rst_wait", 16'(WAIT), 16'd1);
    check_eq("rst_con_valid", 16'(CON_VALID), 16'd0);
    check_eq("rst_con_data", 16'(CON_DATA), 16'h0000);
    check_eq("rst_con_ovf", 16'(CON_OVF), 16'd0);
    check_eq("rst_halted", 16'(HALTED), 16'd0);
    apply_reset();

    // Memory window
    mem_write(16'h8123, 8'hA5);
    mem_write(16'h8000, 8'h3C);
    mem_write(16'hFFFF, 8'h5A);
    mem_write(16'h7FFF, 8'h99);
    mem_read("rd_8123", 16'h8123, 8'hA5);
    mem_read("rd_8000", 16'h8000, 8'h3C);
    mem_read("rd_ffff", 16'hFFFF, 8'h5A);
    mem_read("rd_3fff", 16'h3FFF, 8'hFF);
    mem_read("rd_7fff", 16'h7FFF, 8'hFF);

    // I/O wait length
    con_q.push_back(8'h55);
    ADDRESS = 16'h0010; DATA_o = 8'h55; IORQ = 1'b0; WR = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!WAIT) n++;
      else break;
    end
    check_eq("io_wait_len", 16'(n), 16'd4);
    IORQ = 1'b1; WR = 1'b1;
    tick();
    check_con("io_push");
    apply_reset();

    // Console "HI\r"
    io_write(8'h48, 1'b0);
    io_write(8'h49, 1'b0);
    io_write(8'h0D, 1'b0);
    check_con("hi_head");
    con_pop("hi_pop1");
    con_pop("hi_pop2");
    con_pop("hi_pop3");
    con_pop("hi_pop_empty");

    // Overflow and status byte
    apply_reset();
    for (int i = 1; i <= 5; i++) io_write(8'(i), 1'b0);
    check_con("ovf_fill");
    ADDRESS = 16'h0010; IORQ = 1'b0; RD = 1'b0;
    tick();
    check_eq("status", 16'(DATA_i), 16'h00C1);
    IORQ = 1'b1; RD = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) con_pop("ovf_drain");

    // Push while full with simultaneous pop
    apply_reset();
    for (int i = 1; i <= 4; i++) io_write(8'(i), 1'b0);
    io_write(8'h05, 1'b1);
    check_con("full_pushpop");
    for (int i = 0; i < 4; i++) con_pop("fp_drain");

    // Halt detection
    HALT = 1'b0; tick(); HALT = 1'b1; tick(); tick();
    check_eq("halt_1clk", 16'(HALTED), 16'd0);
    HALT = 1'b0; tick(); tick(); HALT = 1'b1; tick(); tick();
    check_eq("halt_2clk", 16'(HALTED), 16'd1);

    // Asynchronous reset during an I/O wait
    con_q.push_back(8'h77);
    ADDRESS = 16'h0010; DATA_o = 8'h77; IORQ = 1'b0; WR = 1'b0;
    tick();
    check_eq("pre_rst_wait", 16'(WAIT), 16'd0);
    check_eq("pre_rst_valid", 16'(CON_VALID), 16'd1);
    #2 RESET = 1'b0;
    #1;
    check_eq("arst_wait", 16'(WAIT), 16'd1);
    check_eq("arst_halted", 16'(HALTED), 16'd0);
    check_eq("arst_valid", 16'(CON_VALID), 16'd0);
    check_eq("arst_data_i", 16'(DATA_i), 16'h00FF);
    IORQ = 1'b1; WR = 1'b1;
    con_q.delete(); model_ovf = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    check_con("post_rst");
    mem_read("ram_kept", 16'h8123, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
